// File: rtl/nn_fixed_pkg.sv
// Fixed-point helpers shared by the NN datapath blocks (MAC array, pooling, requantiser).
// Accumulator width rule, feature saturation limits and the shift-amount type live here.
package nn_fixed_pkg;

    localparam int SHIFT_W = 6;
    localparam int FEAT_W  = 16;

    typedef logic [SHIFT_W-1:0] shift_t;

    // Worst-case signed accumulator width for an F x W product sum.
    function automatic int acc_width(input int f, input int w);
        return f + w + 1;
    endfunction

    function automatic longint feat_max(input int f);
        return (longint'(1) << (f - 1)) - 64'sd1;
    endfunction

    function automatic longint feat_min(input int f);
        return -(longint'(1) << (f - 1));
    endfunction

    localparam longint FEAT_MAX = feat_max(FEAT_W);
    localparam longint FEAT_MIN = feat_min(FEAT_W);

endpackage

// File: rtl/out_requant_lane.sv
// One requantiser lane: round-half-up arithmetic shift (stage 1 logic) and
// saturate/flag (stage 2 logic). Purely combinational; the top owns the registers.
module out_requant_lane
    import nn_fixed_pkg::*;
#(
    parameter int ACC_W         = 33,
    parameter int FEATURE_WIDTH = 16,
    parameter int SHIFT_WIDTH   = 6
) (
    input  logic signed [ACC_W-1:0]   acc,
    input  logic [SHIFT_WIDTH-1:0]    shift,
    output logic signed [ACC_W:0]     rnd,
    input  logic signed [ACC_W:0]     r,
    input  logic                      relu,
    output logic [FEATURE_WIDTH-1:0]  feat,
    output logic                      sat
);

    localparam int RW = ACC_W + 1;
    localparam int unsigned SMAX = ACC_W - 1;
    localparam logic signed [RW-1:0] MAXV = RW'(feat_max(FEATURE_WIDTH));
    localparam logic signed [RW-1:0] MINV = RW'(feat_min(FEATURE_WIDTH));

    int unsigned          s_eff;
    logic signed [RW-1:0] ext;
    logic signed [RW-1:0] bias;

    // One extra bit of headroom keeps acc + half-LSB from overflowing.
    always_comb begin
        s_eff = (32'(shift) > SMAX) ? SMAX : 32'(shift);
        ext   = {acc[ACC_W-1], acc};
        bias  = '0;
        if (s_eff != 0) begin
            bias = RW'(1) << (s_eff - 1);
        end
        rnd = (ext + bias) >>> s_eff;
    end

    // ReLU clamps before saturation, so a clamped negative lane never flags.
    always_comb begin
        feat = r[FEATURE_WIDTH-1:0];
        sat  = 1'b0;
        if (relu && r[RW-1]) begin
            feat = '0;
        end else if (r > MAXV) begin
            feat = MAXV[FEATURE_WIDTH-1:0];
            sat  = 1'b1;
        end else if (r < MINV) begin
            feat = MINV[FEATURE_WIDTH-1:0];
            sat  = 1'b1;
        end
    end

endmodule

// File: rtl/out_requant.sv
// Multi-channel output requantiser: 2-stage valid/ready pipe, programmable shift,
// saturation counter. Define OUT_REQUANT_RELU_EN to add the per-beat relu_en input.
module out_requant
    import nn_fixed_pkg::*;
#(
    parameter int WEIGHT_WIDTH  = 16,
    parameter int FEATURE_WIDTH = 16,
    parameter int CHANNELS      = 4,
    parameter int SHIFT_WIDTH   = 6,
    parameter int DEFAULT_SHIFT = 7,
    localparam int ACC_W = acc_width(FEATURE_WIDTH, WEIGHT_WIDTH)
) (
    input  logic                                clk,
    input  logic                                reset,
`ifdef OUT_REQUANT_RELU_EN
    input  logic                                relu_en,
`endif
    input  logic                                cfg_we,
    input  logic [SHIFT_WIDTH-1:0]              shift_cfg,
    input  logic                                in_valid,
    output logic                                in_ready,
    input  logic [CHANNELS*ACC_W-1:0]           in_data,
    output logic                                out_valid,
    input  logic                                out_ready,
    output logic [CHANNELS*FEATURE_WIDTH-1:0]   out_data,
    input  logic                                sat_clr,
    output logic [15:0]                         sat_count
);

    localparam int RW = ACC_W + 1;

    logic [SHIFT_WIDTH-1:0]                 shift_q;
    logic                                   advance;
    logic                                   beat_relu;
    logic                                   s1_valid;
    logic                                   s1_relu;
    logic [CHANNELS-1:0][RW-1:0]            s1_r;
    logic [CHANNELS-1:0][RW-1:0]            rnd;
    logic [CHANNELS-1:0][FEATURE_WIDTH-1:0] feat;
    logic [CHANNELS-1:0]                    flags;
    logic                                   out_sat;
    logic                                   sat_inc;

`ifdef OUT_REQUANT_RELU_EN
    assign beat_relu = relu_en;
`else
    assign beat_relu = 1'b0;
`endif

    // Valid/ready: a beat moves on a rising edge where valid && ready; in_ready never
    // looks at in_valid. The whole pipe advances together, so a held output freezes it.
    assign advance  = !out_valid || out_ready;
    assign in_ready = advance;

    for (genvar i = 0; i < CHANNELS; i++) begin : g_lane
        out_requant_lane #(
            .ACC_W        (ACC_W),
            .FEATURE_WIDTH(FEATURE_WIDTH),
            .SHIFT_WIDTH  (SHIFT_WIDTH)
        ) u_lane (
            .acc  (in_data[i*ACC_W +: ACC_W]),
            .shift(shift_q),
            .rnd  (rnd[i]),
            .r    (s1_r[i]),
            .relu (s1_relu),
            .feat (feat[i]),
            .sat  (flags[i])
        );
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shift_q <= SHIFT_WIDTH'(DEFAULT_SHIFT);
        end else if (cfg_we) begin
            shift_q <= shift_cfg;
        end
    end

    // Rounding uses shift_q at acceptance, so later cfg writes cannot touch this beat.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_valid <= 1'b0;
            s1_relu  <= 1'b0;
            s1_r     <= '0;
        end else if (advance) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_r    <= rnd;
                s1_relu <= beat_relu;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sat   <= 1'b0;
        end else if (advance) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                out_data <= feat;
                out_sat  <= |flags;
            end
        end
    end

    assign sat_inc = out_valid && out_ready && out_sat;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sat_count <= '0;
        end else if (sat_clr) begin
            sat_count <= sat_inc ? 16'd1 : 16'd0;
        end else if (sat_inc && sat_count != 16'hFFFF) begin
            sat_count <= sat_count + 16'd1;
        end
    end

endmodule

// File: tb/tb_out_requant.sv
// Testbench for out_requant: vector table, hand-written pipeline corner sequences and
// a random backpressure run, all checked through an expected-beat queue.
module tb_out_requant;

    localparam int CH    = 4;
    localparam int F     = 16;
    localparam int ACC_W = 33;
    localparam int OW    = CH * F;
    localparam int IW    = CH * ACC_W;

    logic              clk;
    logic              reset;
    logic              cfg_we;
    logic [5:0]        shift_cfg;
    logic              in_valid;
    logic              in_ready;
    logic [IW-1:0]     in_data;
    logic              out_valid;
    logic              out_ready;
    logic [OW-1:0]     out_data;
    logic              sat_clr;
    logic [15:0]       sat_count;
`ifdef OUT_REQUANT_RELU_EN
    logic              relu_en;
`endif

    int                n_vec = 0;
    int                n_err = 0;
    logic [OW:0]       exp_q[$];
    logic [OW:0]       cur_exp;
    logic [15:0]       mdl_cnt;
    int                drv_shift;
    bit                drv_relu;
    bit                rand_bp;

    out_requant dut (
        .clk      (clk),
        .reset    (reset),
`ifdef OUT_REQUANT_RELU_EN
        .relu_en  (relu_en),
`endif
        .cfg_we   (cfg_we),
        .shift_cfg(shift_cfg),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .sat_clr  (sat_clr),
        .sat_count(sat_count)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation still running, expected finish");
        $fatal(1, "watchdog");
    end

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [IW-1:0] pack_in(input longint a0, input longint a1,
                                              input longint a2, input longint a3);
        return {a3[ACC_W-1:0], a2[ACC_W-1:0], a1[ACC_W-1:0], a0[ACC_W-1:0]};
    endfunction

    function automatic logic [OW:0] pack_exp(input int e0, input int e1, input int e2,
                                             input int e3, input bit s);
        return {s, e3[F-1:0], e2[F-1:0], e1[F-1:0], e0[F-1:0]};
    endfunction

    // Reference: floor((x + 2^(s-1)) / 2^s), then optional relu, then clamp.
    function automatic logic [OW:0] model_beat(input logic [IW-1:0] d, input int s, input bit relu);
        logic [OW:0]             r;
        logic signed [ACC_W-1:0] a;
        longint                  x, num, den, q;
        int                      se;
        r   = '0;
        se  = (s > ACC_W - 1) ? ACC_W - 1 : s;
        den = longint'(1) << se;
        for (int i = 0; i < CH; i++) begin
            a   = d[i*ACC_W +: ACC_W];
            x   = longint'(a);
            num = x + ((se == 0) ? 64'sd0 : den / 2);
            q   = num / den;
            if ((num % den) != 0 && num < 0) q = q - 1;
            if (relu && q < 0) q = 0;
            else if (q > 32767) begin q = 32767; r[OW] = 1'b1; end
            else if (q < -32768) begin q = -32768; r[OW] = 1'b1; end
            r[i*F +: F] = q[F-1:0];
        end
        return r;
    endfunction

    // ---------------- scoreboard ----------------
    always @(negedge clk) begin : scoreboard
        logic [OW:0] e;
        logic        inc;
        if (reset) begin
            exp_q.delete();
            mdl_cnt = '0;
        end else begin
            inc = 1'b0;
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_beat: got %h expected no beat", out_data);
                end else begin
                    e = exp_q.pop_front();
                    check("out_data", 64'(out_data), 64'(e[OW-1:0]));
                    inc = e[OW];
                end
            end
            if (sat_clr) mdl_cnt = inc ? 16'd1 : 16'd0;
            else if (inc && mdl_cnt != 16'hFFFF) mdl_cnt = mdl_cnt + 16'd1;
            if (in_valid && in_ready) exp_q.push_back(cur_exp);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic step();
        tick();
        if (rand_bp) out_ready = ($urandom_range(0, 3) != 0);
    endtask

    task automatic cfg(input int s);
        cfg_we    = 1'b1;
        shift_cfg = s[5:0];
        tick();
        cfg_we    = 1'b0;
        drv_shift = s;
    endtask

    task automatic send(input logic [IW-1:0] d, input logic [OW:0] e);
        bit took;
        in_valid = 1'b1;
        in_data  = d;
        cur_exp  = e;
        took     = 1'b0;
        for (int k = 0; k < 100 && !took; k++) begin
            @(negedge clk);
            took = in_ready;
            step();
        end
        if (!took) begin
            n_vec++;
            n_err++;
            $display("FAIL send_timeout: got in_ready=0 expected acceptance within 100 cycles");
        end
    endtask

    task automatic drain(input int budget);
        int k;
        in_valid  = 1'b0;
        rand_bp   = 1'b0;
        out_ready = 1'b1;
        k = 0;
        while (exp_q.size() != 0 && k < budget) begin
            tick();
            k++;
        end
        if (exp_q.size() != 0) begin
            n_vec++;
            n_err++;
            $display("FAIL drain_timeout: got %0d beats pending expected 0", exp_q.size());
        end
        tick();
        check("sat_count", 64'(sat_count), 64'(mdl_cnt));
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        int     shift;
        longint a0, a1, a2, a3;
        int     e0, e1, e2, e3;
        bit     sat;
    } vec_t;

    vec_t tbl[7];

    initial begin
        logic [OW:0]   ep;
        logic [IW-1:0] d;
        int            lat;

        tbl[0] = '{7, 1000, -1000, 0, 63, 8, -8, 0, 0, 1'b0};
        tbl[1] = '{7, 64'sd1073741824, -64'sd1073741824, 0, 0, 32767, -32768, 0, 0, 1'b1};
        tbl[2] = '{7, 64, -64, 63, -65, 1, 0, 0, -1, 1'b0};
        tbl[3] = '{0, 32767, -32768, 32768, -32769, 32767, -32768, 32767, -32768, 1'b1};
        tbl[4] = '{1, 3, -3, 1, -1, 2, -1, 1, 0, 1'b0};
        tbl[5] = '{40, 64'sd4294967295, -64'sd4294967296, 64'sd2147483648, -64'sd2147483648,
                   1, -1, 1, 0, 1'b0};
        tbl[6] = '{16, 64'sd2147418112, 64'sd2147450880, -64'sd2147483648, -64'sd2147516417,
                   32767, 32767, -32768, -32768, 1'b1};

        reset = 1'b1; cfg_we = 1'b0; shift_cfg = '0; in_valid = 1'b0; in_data = '0;
        out_ready = 1'b1; sat_clr = 1'b0; cur_exp = '0; mdl_cnt = '0;
        drv_shift = 7; drv_relu = 1'b0; rand_bp = 1'b0;
`ifdef OUT_REQUANT_RELU_EN
        relu_en = 1'b0;
`endif
        repeat (3) tick();
        reset = 1'b0;

        // Reset state
        @(negedge clk);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_out_data", 64'(out_data), 64'd0);
        check("rst_sat_count", 64'(sat_count), 64'd0);
        tick();

        // Two-cycle latency, default shift of 7
        in_valid = 1'b1;
        in_data  = pack_in(tbl[0].a0, tbl[0].a1, tbl[0].a2, tbl[0].a3);
        cur_exp  = pack_exp(tbl[0].e0, tbl[0].e1, tbl[0].e2, tbl[0].e3, tbl[0].sat);
        tick();
        in_valid = 1'b0;
        lat = 1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (out_valid) break;
            tick();
            lat++;
        end
        check("latency", 64'(lat), 64'd2);
        drain(20);

        // Vector table, back to back where the shift does not change
        for (int i = 0; i < 7; i++) begin
            if (tbl[i].shift != drv_shift) begin
                in_valid = 1'b0;
                cfg(tbl[i].shift);
            end
            send(pack_in(tbl[i].a0, tbl[i].a1, tbl[i].a2, tbl[i].a3),
                 pack_exp(tbl[i].e0, tbl[i].e1, tbl[i].e2, tbl[i].e3, tbl[i].sat));
        end
        drain(50);
        check("sat_count_table", 64'(sat_count), 64'd3);

        // cfg_we in the same cycle as the first of two back-to-back beats
        cfg(7);
        in_valid = 1'b1; in_data = pack_in(5, 5, 5, 5); cur_exp = pack_exp(0, 0, 0, 0, 1'b0);
        cfg_we = 1'b1; shift_cfg = 6'd0;
        tick();
        cfg_we = 1'b0; drv_shift = 0; cur_exp = pack_exp(5, 5, 5, 5, 1'b0);
        tick();
        in_valid = 1'b0;
        @(negedge clk);
        check("nobubble_first", 64'(out_valid), 64'd1);
        tick();
        @(negedge clk);
        check("nobubble_second", 64'(out_valid), 64'd1);
        drain(20);

        // Output stall with two beats in flight and a third waiting
        in_valid = 1'b1; in_data = pack_in(100, -100, 7, -7);
        ep = pack_exp(100, -100, 7, -7, 1'b0); cur_exp = ep;
        tick();
        in_data = pack_in(1, 2, 3, 4); cur_exp = pack_exp(1, 2, 3, 4, 1'b0);
        tick();
        out_ready = 1'b0;
        in_data = pack_in(40000, -40000, 0, 1); cur_exp = pack_exp(32767, -32768, 0, 1, 1'b1);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("stall_in_ready", 64'(in_ready), 64'd0);
            check("stall_out_valid", 64'(out_valid), 64'd1);
            check("stall_out_data", 64'(out_data), 64'(ep[OW-1:0]));
            tick();
        end
        out_ready = 1'b1;
        tick();
        drain(20);

        // Reset with the pipe full of saturating beats
        cfg(3);
        for (int k = 0; k < 3; k++) begin
            send(pack_in(64'sd1073741824, 0, 0, 0), pack_exp(32767, 0, 0, 0, 1'b1));
        end
        check("sat_pre_reset", 64'(sat_count), 64'(mdl_cnt));
        reset = 1'b1; in_valid = 1'b0;
        @(negedge clk);
        check("midrst_out_valid", 64'(out_valid), 64'd0);
        check("midrst_sat_count", 64'(sat_count), 64'd0);
        check("midrst_in_ready", 64'(in_ready), 64'd1);
        tick();
        reset = 1'b0; drv_shift = 7;
        send(pack_in(tbl[0].a0, tbl[0].a1, tbl[0].a2, tbl[0].a3),
             pack_exp(tbl[0].e0, tbl[0].e1, tbl[0].e2, tbl[0].e3, tbl[0].sat));
        drain(20);

        // sat_clr alone, and sat_clr coinciding with a saturating beat
        send(pack_in(64'sd1073741824, 0, 0, 0), pack_exp(32767, 0, 0, 0, 1'b1));
        send(pack_in(0, -64'sd1073741824, 0, 0), pack_exp(0, -32768, 0, 0, 1'b1));
        drain(20);
        check("sat_two", 64'(sat_count), 64'd2);
        sat_clr = 1'b1;
        tick();
        sat_clr = 1'b0;
        check("sat_clr_only", 64'(sat_count), 64'd0);
        send(pack_in(64'sd1073741824, 0, 0, 0), pack_exp(32767, 0, 0, 0, 1'b1));
        in_valid = 1'b0;
        tick();
        sat_clr = 1'b1;
        tick();
        sat_clr = 1'b0;
        check("sat_clr_inc", 64'(sat_count), 64'd1);
        drain(20);

`ifdef OUT_REQUANT_RELU_EN
        // ReLU clamps negatives without flagging saturation
        relu_en = 1'b1;
        send(pack_in(-1000, -64'sd1073741824, -1, -64), pack_exp(0, 0, 0, 0, 1'b0));
        send(pack_in(-1000, 1000, 0, 64'sd1073741824), pack_exp(0, 8, 0, 32767, 1'b1));
        relu_en = 1'b0;
        drain(20);
        check("relu_sat_count", 64'(sat_count), 64'd2);
`endif

        // Random stream with backpressure and shift changes
        rand_bp = 1'b1;
        for (int i = 0; i < 200; i++) begin
            if ($urandom_range(0, 7) == 0) begin
                in_valid = 1'b0;
                if ($urandom_range(0, 1) == 0) cfg($urandom_range(0, 40));
                else step();
            end else begin
                for (int l = 0; l < CH; l++) begin
                    case ($urandom_range(0, 2))
                        0: d[l*ACC_W +: ACC_W] = ACC_W'($signed(20'($urandom_range(0, 4095))) - 2048);
                        1: d[l*ACC_W +: ACC_W] = ACC_W'($signed(28'($urandom_range(0, 2**24 - 1))) - 28'sd8388608);
                        default: d[l*ACC_W +: ACC_W] = {1'($urandom_range(0, 1)), 32'($urandom)};
                    endcase
                end
`ifdef OUT_REQUANT_RELU_EN
                drv_relu = ($urandom_range(0, 3) == 0);
                relu_en  = drv_relu;
`endif
                send(d, model_beat(d, drv_shift, drv_relu));
            end
        end
        drain(200);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
